alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one `alu` instance between two requesters, for example the execute stage and a branch/address helper. It arbitrates with round-robin priority, uses valid/ready handshakes on both sides, and holds each result in a one-entry output register. Results are tagged with the winning requester's ID. The block also keeps saturating per-requester grant counters for performance debug.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width
- `OPCODE_LENGTH`, 4, ALU operation code width
- `CNT_WIDTH`, 16, grant counter width

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req0_valid`  in  1  requester 0 has an operation
- `req0_ready`  out  1  requester 0 operation accepted this cycle
- `req0_srca`, `req0_srcb`  in  DATA_WIDTH  operands
- `req0_op`  in  OPCODE_LENGTH  ALU operation code
- `req1_valid`, `req1_ready`, `req1_srca`, `req1_srcb`, `req1_op`  same as requester 0, for requester 1
- `rsp_valid`  out  1  result held
- `rsp_ready`  in  1  consumer takes result
- `rsp_id`  out  1  requester that owns the result
- `rsp_result`  out  DATA_WIDTH  ALU result
- `grant_cnt0`, `grant_cnt1`  out  CNT_WIDTH  saturating accepted-request counts

## Operation
- Output state machine, `arb_state_e`:
  - EMPTY: no result held.
  - FULL: result held.
  - Transitions:
    - EMPTY → FULL on accept.
    - FULL → EMPTY on drain without accept.
    - FULL → FULL on drain plus accept in the same cycle.
    - FULL with no drain holds.
- `can_accept` = (state == EMPTY) | rsp_ready.
- Grant selection:
  - Only one valid requester: that requester gets the grant.
  - Both valid: the requester not granted last (`last_grant`) wins.
  - `reqN_ready` = can_accept & grant==N; at most one ready is high per cycle.
- On accept:
  - The winning request's srca/srcb/op drive the combinational `alu`.
  - `ALUResult` is captured into `rsp_result`, and `rsp_id` is set to the winner.
  - `last_grant` is updated to the winner.
  - `grant_cntN` increments, saturating at all-ones.
- Operation codes pass to the ALU unchanged:
  - 1001, 1110 and 1111 yield 0.
  - Comparison codes yield 0/1.
  - No error is flagged.
- Handshake rules:
  - A requester keeps valid high with a stable payload until ready.
  - `rsp_valid`/`rsp_id`/`rsp_result` are stable while FULL and not drained.
  - `rsp_valid` never depends combinationally on `rsp_ready`.
  - `reqN_ready` depends combinationally on both valids, `rsp_ready` and state.

## Timing
- Reset values:
  - state EMPTY, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0.
  - `last_grant`=1, so requester 0 wins the first tie.
  - Counters 0.
- Latency: accept in cycle N gives `rsp_valid`=1 in cycle N+1.
- Throughput: one operation per cycle while `rsp_ready` is held high.
- Backpressure: FULL with `rsp_ready`=0 forces both `reqN_ready`=0. Requests wait, and no requester is starved beyond one grant of the other.
- Simultaneous drain and accept: the old result is consumed at the edge and the new result is visible the next cycle; no bubble.
- Reset asserted mid-operation:
  - The held result is discarded.
  - Outputs return to their reset values immediately (asynchronously).
  - The first accept can occur on the first rising edge after deassertion.
- Counter saturation: at all-ones, further grants leave the count unchanged.

## Structure
- Package `alu_arbiter_pkg`:
  - `alu_op_e` enum: ADD=0000, SUB=0001, XOR=0010, OR=0011, AND=0100, SLT=0101, SRA=0110, SRL=0111, SLL=1000, LDST=1001, BNE=1010, BLT=1011, BGE=1100, BEQ=1101.
  - `arb_state_e` enum: EMPTY, FULL.
- Sub-module: one instance of the existing `alu` (DATA_WIDTH, OPCODE_LENGTH passed through). Arbitration, state machine and counters are in `alu_arbiter` itself.

## Test plan
- After reset, only req0 valid with srca=5, srcb=3, op=ADD → `req0_ready`=1 that cycle. Next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_result`=8, `grant_cnt0`=1.
- Both valid continuously with `rsp_ready`=1:
  - req0: SUB 10,4. req1: SLT -1,2.
  - Grants alternate 0,1,0,1; results alternate 6 and 1; both counters advance equally.
- `rsp_ready`=0 for 3 cycles while FULL → `reqN_ready`=0 and the result is stable. Raise `rsp_ready` with req1 valid → drain and accept in the same cycle, with no idle cycle on `rsp_valid`.
- req1 SRA srca=0x80000000, srcb=4 → 0xF8000000. Op 1111 → result 0, `rsp_valid`=1.
- Reset pulse while FULL with `grant_cnt0`=7 → `rsp_valid`=0 and counters 0 immediately. First tie after release is granted to req0.
- Force `grant_cnt0` near saturation with `CNT_WIDTH`=4 and issue 20 req0 grants → counter holds at 15.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: ALU opcodes and the
// output-register state.
package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'b0000,
        SUB  = 4'b0001,
        XOR  = 4'b0010,
        OR   = 4'b0011,
        AND  = 4'b0100,
        SLT  = 4'b0101,
        SRA  = 4'b0110,
        SRL  = 4'b0111,
        SLL  = 4'b1000,
        LDST = 4'b1001,
        BNE  = 4'b1010,
        BLT  = 4'b1011,
        BGE  = 4'b1100,
        BEQ  = 4'b1101
    } alu_op_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters. Unused codes, including
// LDST, return zero; comparisons return 0/1 and no error is flagged.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    srca,
    input  logic [DATA_WIDTH-1:0]    srcb,
    input  logic [OPCODE_LENGTH-1:0] alucontrol,
    output logic [DATA_WIDTH-1:0]    aluresult
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0] shamt;
    logic           lt_s;

    assign shamt = srcb[SHW-1:0];
    assign lt_s  = $signed(srca) < $signed(srcb);

    always_comb begin
        aluresult = '0;
        case (alucontrol)
            ADD:  aluresult = srca + srcb;
            SUB:  aluresult = srca - srcb;
            XOR:  aluresult = srca ^ srcb;
            OR:   aluresult = srca | srcb;
            AND:  aluresult = srca & srcb;
            SLT:  aluresult = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            SRA:  aluresult = $signed(srca) >>> shamt;
            SRL:  aluresult = srca >> shamt;
            SLL:  aluresult = srca << shamt;
            BNE:  aluresult = {{(DATA_WIDTH-1){1'b0}}, srca != srcb};
            BLT:  aluresult = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            BGE:  aluresult = {{(DATA_WIDTH-1){1'b0}}, ~lt_s};
            BEQ:  aluresult = {{(DATA_WIDTH-1){1'b0}}, srca == srcb};
            default: aluresult = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters,
// with a one-entry tagged result register and saturating grant counters.
//
// state | meaning
// EMPTY | no result held; any valid request can be accepted
// FULL  | result held in rsp_*; accept only when it drains this cycle
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_srca,
    input  logic [DATA_WIDTH-1:0]    req0_srcb,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_srca,
    input  logic [DATA_WIDTH-1:0]    req1_srcb,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [DATA_WIDTH-1:0]    rsp_result,
    output logic [CNT_WIDTH-1:0]     grant_cnt0,
    output logic [CNT_WIDTH-1:0]     grant_cnt1
);

    arb_state_e state, state_next;
    logic       last_grant;
    logic       grant;
    logic       can_accept;
    logic       accept;

    logic [DATA_WIDTH-1:0]    alu_srca;
    logic [DATA_WIDTH-1:0]    alu_srcb;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic [DATA_WIDTH-1:0]    alu_result;

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        can_accept = (state == EMPTY) | rsp_ready;

        // On a tie the requester that did not win last time goes first.
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else
            grant = req1_valid;

        accept     = can_accept & (req0_valid | req1_valid);
        req0_ready = accept & ~grant;
        req1_ready = accept & grant;

        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (rsp_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    assign alu_srca = grant ? req1_srca : req0_srca;
    assign alu_srcb = grant ? req1_srcb : req0_srcb;
    assign alu_op   = grant ? req1_op   : req0_op;

    alu #(
        .DATA_WIDTH   (DATA_WIDTH),
        .OPCODE_LENGTH(OPCODE_LENGTH)
    ) u_alu (
        .srca      (alu_srca),
        .srcb      (alu_srcb),
        .alucontrol(alu_op),
        .aluresult (alu_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                rsp_id     <= grant;
                rsp_result <= alu_result;
                last_grant <= grant;
                if (!grant && grant_cnt0 != '1)
                    grant_cnt0 <= grant_cnt0 + CNT_WIDTH'(1);
                if (grant && grant_cnt1 != '1)
                    grant_cnt1 <= grant_cnt1 + CNT_WIDTH'(1);
            end
        end
    end

    assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter, checked against a
// queue-based model of the arbiter and a reference ALU.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
    logic [3:0]  req0_op, req1_op;
    logic        rsp_ready;

    logic        req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [31:0] rsp_result;
    logic [15:0] grant_cnt0, grant_cnt1;

    logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id;
    logic [31:0] s_rsp_result;
    logic [3:0]  s_grant_cnt0, s_grant_cnt1;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_res[$];
    bit          q_id[$];
    bit          m_last;
    int          m_cnt0, m_cnt1, m_s0, m_s1;
    int          last_g;

    alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready),
        .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready),
        .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_op(req1_op),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
        .rsp_result(s_rsp_result), .grant_cnt0(s_grant_cnt0), .grant_cnt1(s_grant_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (int'(op))
            0:  return a + b;
            1:  return a - b;
            2:  return a ^ b;
            3:  return a | b;
            4:  return a & b;
            5:  return (sa < sb) ? 32'd1 : 32'd0;
            6:  return 32'(sa >>> b[4:0]);
            7:  return a >> b[4:0];
            8:  return a << b[4:0];
            10: return (a != b) ? 32'd1 : 32'd0;
            11: return (sa < sb) ? 32'd1 : 32'd0;
            12: return (sa >= sb) ? 32'd1 : 32'd0;
            13: return (a == b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_res.delete();
        q_id.delete();
        m_last = 1'b1;
        m_cnt0 = 0; m_cnt1 = 0; m_s0 = 0; m_s1 = 0;
    endtask

    // One clock: predict the grant, check readies before the edge, then
    // advance the model and check the registered outputs after it.
    task automatic step();
        int  g;
        bit  can;
        can = (q_res.size() == 0) || rsp_ready;
        g = -1;
        if (req0_valid && req1_valid) g = m_last ? 0 : 1;
        else if (req0_valid)          g = 0;
        else if (req1_valid)          g = 1;
        if (!can) g = -1;
        #1;
        check("req0_ready", 64'(req0_ready), 64'(g == 0));
        check("req1_ready", 64'(req1_ready), 64'(g == 1));
        @(posedge clk);
        #1;
        if (rsp_ready && q_res.size() != 0) begin
            void'(q_res.pop_front());
            void'(q_id.pop_front());
        end
        if (g == 0) begin
            q_res.push_back(ref_alu(req0_op, req0_srca, req0_srcb));
            q_id.push_back(1'b0);
            m_cnt0 = (m_cnt0 < 65535) ? m_cnt0 + 1 : m_cnt0;
            m_s0   = (m_s0 < 15) ? m_s0 + 1 : m_s0;
            m_last = 1'b0;
        end else if (g == 1) begin
            q_res.push_back(ref_alu(req1_op, req1_srca, req1_srcb));
            q_id.push_back(1'b1);
            m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : m_cnt1;
            m_s1   = (m_s1 < 15) ? m_s1 + 1 : m_s1;
            m_last = 1'b1;
        end
        last_g = g;
        check("rsp_valid", 64'(rsp_valid), 64'(q_res.size() != 0));
        if (q_res.size() != 0) begin
            check("rsp_id", 64'(rsp_id), 64'(q_id[0]));
            check("rsp_result", 64'(rsp_result), 64'(q_res[0]));
        end
        check("grant_cnt0", 64'(grant_cnt0), 64'(m_cnt0));
        check("grant_cnt1", 64'(grant_cnt1), 64'(m_cnt1));
        check("small_cnt0", 64'(s_grant_cnt0), 64'(m_s0));
        check("small_cnt1", 64'(s_grant_cnt1), 64'(m_s1));
        @(negedge clk);
    endtask

    // Called at a falling edge; asserts reset mid-cycle and checks the
    // asynchronous clear before the next rising edge.
    task automatic pulse_reset();
        #1 reset = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_result", 64'(rsp_result), 64'd0);
        check("rst_cnt0", 64'(grant_cnt0), 64'd0);
        check("rst_cnt1", 64'(grant_cnt1), 64'd0);
        model_reset();
        reset = 1'b1;
    endtask

    task automatic set_req0(input logic v, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        req0_valid = v; req0_op = op; req0_srca = a; req0_srcb = b;
    endtask

    task automatic set_req1(input logic v, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        req1_valid = v; req1_op = op; req1_srca = a; req1_srcb = b;
    endtask

    function automatic logic [31:0] rnd_operand();
        return ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : 32'($urandom);
    endfunction

    initial begin
        reset = 1'b0;
        rsp_ready = 1'b0;
        set_req0(1'b0, 4'd0, 32'd0, 32'd0);
        set_req1(1'b0, 4'd0, 32'd0, 32'd0);
        model_reset();
        last_g = -1;
        #12;
        check("init_rsp_valid", 64'(rsp_valid), 64'd0);
        check("init_rsp_result", 64'(rsp_result), 64'd0);
        check("init_cnt0", 64'(grant_cnt0), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single requester ADD 5+3.
        set_req0(1'b1, 4'd0, 32'd5, 32'd3);
        step();
        check("add_result", 64'(rsp_result), 64'd8);
        check("add_cnt0", 64'(grant_cnt0), 64'd1);

        // Both valid, continuous drain: grants alternate.
        rsp_ready = 1'b1;
        set_req0(1'b1, 4'd1, 32'd10, 32'd4);
        set_req1(1'b1, 4'd5, 32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < 4; i++) step();
        check("alt_cnt_diff", 64'(grant_cnt0 - grant_cnt1), 64'd1);

        // Backpressure while full, then drain plus accept together.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rsp_ready = 1'b1;
        req0_valid = 1'b0;
        step();
        check("no_bubble_id", 64'(rsp_id), 64'd1);

        set_req1(1'b1, 4'd6, 32'h8000_0000, 32'd4);
        step();
        check("sra_result", 64'(rsp_result), 64'hF800_0000);
        set_req1(1'b1, 4'd15, 32'd123, 32'd45);
        step();
        check("op15_result", 64'(rsp_result), 64'd0);
        check("op15_valid", 64'(rsp_valid), 64'd1);

        // Reset while full with grant_cnt0 = 7.
        set_req1(1'b0, 4'd0, 32'd0, 32'd0);
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            set_req0(1'b1, 4'd0, rnd_operand(), rnd_operand());
            step();
        end
        check("cnt0_seven", 64'(grant_cnt0), 64'd7);
        rsp_ready = 1'b0;
        req0_valid = 1'b0;
        step();
        pulse_reset();
        set_req0(1'b1, 4'd2, 32'hA5, 32'h5A);
        set_req1(1'b1, 4'd3, 32'h11, 32'h22);
        step();
        check("first_tie_id", 64'(rsp_id), 64'd0);

        // Randomized traffic with legal requester behaviour.
        for (int i = 0; i < 300; i++) begin
            if (last_g == 0 || !req0_valid)
                set_req0(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                         rnd_operand(), rnd_operand());
            if (last_g == 1 || !req1_valid)
                set_req1(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                         rnd_operand(), rnd_operand());
            rsp_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end

        // Counter saturation on the 4-bit instance.
        set_req1(1'b0, 4'd0, 32'd0, 32'd0);
        rsp_ready = 1'b1;
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            set_req0(1'b1, 4'($urandom_range(0, 15)), rnd_operand(), rnd_operand());
            step();
        end
        check("sat_small_cnt0", 64'(s_grant_cnt0), 64'd15);
        check("wide_cnt0", 64'(grant_cnt0), 64'd20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
